xdma_clock_gen: RTL and testbench

- Multi-channel, runtime-programmable clock divider for the FPGA-sim XDMA clocking path.
- Generalises the fixed compile-time divide-by-2N generator: per-channel half-period programmed over a valid/ready config port, glitch-free ratio changes at phase boundaries, clean per-channel stop/start, and a source-domain rising-edge strobe for CDC logic.
- Every output clock is a flop output clocked by the single source clock.

---
 rtl/xdma_clock_gen.sv | 114 +++++++++++
 tb/tb_xdma_clock_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xdma_clock_gen.sv
`timescale 1ns/1ps
// Multi-channel runtime-programmable clock divider; each clock_out is a flop toggling every half_cur source cycles.
// Outputs are registered; cfg_ready drops only while the addressed channel still holds an unapplied ratio.
module xdma_clock_gen #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 1,
  parameter bit EN_AT_RESET  = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en_in,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] running,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0] DEF_HALF = (DEFAULT_HALF == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0]  r_cnt       [NUM_CH];
  logic [CNT_W-1:0]  r_half_cur  [NUM_CH];
  logic [CNT_W-1:0]  r_half_pend [NUM_CH];
  logic [NUM_CH-1:0] r_pend_vld;
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] r_rise;
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_armed;
  logic              r_err;

  logic [NUM_CH-1:0] w_en;
  logic [NUM_CH-1:0] w_tc;
  logic [NUM_CH-1:0] w_wr;
  logic [15:0]       w_pend16;
  logic              w_ch_ok;
  logic [CNT_W-1:0]  w_half_new;

  assign w_ch_ok    = (32'(cfg_ch) < NUM_CH);
  assign w_pend16   = 16'(r_pend_vld);
  assign cfg_ready  = !(w_ch_ok && w_pend16[cfg_ch]);
  assign w_half_new = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  assign w_en       = en_in & r_armed;

  always_comb begin
    w_tc = '0;
    w_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_tc[i] = (r_cnt[i] == r_half_cur[i] - CNT_W'(1));
      w_wr[i] = cfg_valid && cfg_ready && (cfg_ch == 4'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]       <= '0;
        r_half_cur[i]  <= DEF_HALF;
        r_half_pend[i] <= DEF_HALF;
      end
      r_pend_vld <= '0;
      r_clk      <= '0;
      r_rise     <= '0;
      r_run      <= '0;
      r_armed    <= {NUM_CH{EN_AT_RESET}};
      r_err      <= 1'b0;
    end else begin
      if (cfg_valid && !w_ch_ok) r_err <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        r_rise[i] <= 1'b0;
        if (en_in[i]) r_armed[i] <= 1'b1;
        if (!r_run[i]) begin
          r_cnt[i] <= '0;
          if (r_pend_vld[i]) begin
            r_half_cur[i] <= r_half_pend[i];
            r_pend_vld[i] <= 1'b0;
          end
          if (w_en[i]) r_run[i] <= 1'b1;
        end else if (!r_clk[i] && !w_en[i]) begin
          r_run[i] <= 1'b0;
          r_cnt[i] <= '0;
        end else if (w_tc[i]) begin
          r_cnt[i] <= '0;
          r_clk[i] <= !r_clk[i];
          // Falling edge is the only safe point to swap ratio or stop without a runt phase.
          if (r_clk[i]) begin
            if (r_pend_vld[i]) begin
              r_half_cur[i] <= r_half_pend[i];
              r_pend_vld[i] <= 1'b0;
            end
            if (!w_en[i]) r_run[i] <= 1'b0;
          end else begin
            r_rise[i] <= 1'b1;
          end
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
        if (w_wr[i]) begin
          r_half_pend[i] <= w_half_new;
          r_pend_vld[i]  <= 1'b1;
        end
      end
    end
  end

  assign clock_out  = r_clk;
  assign rise_pulse = r_rise;
  assign running    = r_run;
  assign cfg_err    = r_err;

endmodule

// File: tb/tb_xdma_clock_gen.sv
`timescale 1ns/1ps
// Bench for xdma_clock_gen: reset vector table, directed ratio/enable/reset sequences, then random traffic
// compared every cycle against a phase-countdown model of the divider.
module tb_xdma_clock_gen;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b1;
  logic [NUM_CH-1:0] en_in   = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [3:0]        cfg_ch  = '0;
  logic [CNT_W-1:0]  cfg_half = '0;
  logic [NUM_CH-1:0] clock_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] running;
  logic              cfg_err;

  xdma_clock_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(1), .EN_AT_RESET(1'b1)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .en_in      (en_in),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_half   (cfg_half),
    .clock_out  (clock_out),
    .rise_pulse (rise_pulse),
    .running    (running),
    .cfg_err    (cfg_err)
  );

  always #5 clock = ~clock;

  int   checks   = 0;
  int   failures = 0;
  logic rdy_pre;

  // Reference model: cycles left in the current phase rather than an up-counter.
  int m_left [NUM_CH];
  int m_half [NUM_CH];
  int m_pend [NUM_CH];
  bit m_lvl  [NUM_CH];
  bit m_run  [NUM_CH];
  bit m_rise [NUM_CH];
  bit m_err;

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic              vld;
    logic [3:0]        ch;
    logic [CNT_W-1:0]  half;
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] run;
    logic              err;
    logic              rdy;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_left[c] = 0; m_half[c] = 1; m_pend[c] = 0;
      m_lvl[c] = 0; m_run[c] = 0; m_rise[c] = 0;
    end
    m_err = 0;
  endtask

  function automatic bit model_ready();
    if (int'(cfg_ch) >= NUM_CH) return 1'b1;
    return m_pend[int'(cfg_ch)] == 0;
  endfunction

  function automatic logic [NUM_CH-1:0] m_vec(input int which);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++)
      v[c] = (which == 0) ? m_lvl[c] : (which == 1) ? m_rise[c] : m_run[c];
    return v;
  endfunction

  task automatic model_step();
    bit acc;
    acc = cfg_valid && model_ready();
    for (int c = 0; c < NUM_CH; c++) begin
      m_rise[c] = 0;
      if (!m_run[c]) begin
        if (m_pend[c] != 0) begin m_half[c] = m_pend[c]; m_pend[c] = 0; end
        if (en_in[c]) begin m_run[c] = 1; m_lvl[c] = 0; m_left[c] = m_half[c]; end
      end else if (!m_lvl[c] && !en_in[c]) begin
        m_run[c] = 0;
      end else begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          if (m_lvl[c]) begin
            m_lvl[c] = 0;
            if (m_pend[c] != 0) begin m_half[c] = m_pend[c]; m_pend[c] = 0; end
            if (!en_in[c]) m_run[c] = 0;
          end else begin
            m_lvl[c] = 1; m_rise[c] = 1;
          end
          m_left[c] = m_half[c];
        end
      end
    end
    if (acc) begin
      if (int'(cfg_ch) < NUM_CH) m_pend[int'(cfg_ch)] = (cfg_half == 0) ? 1 : int'(cfg_half);
      else m_err = 1;
    end
  endtask

  task automatic tick();
    #1;
    rdy_pre = cfg_ready;
    check("cfg_ready", cfg_ready, model_ready());
    @(posedge clock);
    model_step();
    #1;
    check("clock_out", clock_out, m_vec(0));
    check("rise_pulse", rise_pulse, m_vec(1));
    check("running", running, m_vec(2));
    check("cfg_err", cfg_err, m_err);
  endtask

  task automatic run_len(input int c, input logic lvl, output int n);
    n = 1;
    while (n < 1000) begin
      tick();
      if (clock_out[c] !== lvl) break;
      n++;
    end
  endtask

  task automatic cfg_write(input int c, input int h);
    cfg_valid = 1'b1; cfg_ch = 4'(c); cfg_half = CNT_W'(h);
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (rdy_pre) break;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_pend(input int c);
    for (int k = 0; k < 2000 && m_pend[c] != 0; k++) tick();
  endtask

  task automatic do_reset();
    en_in = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_clock_out", clock_out, 0);
    check("rst_rise_pulse", rise_pulse, 0);
    check("rst_running", running, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    int stall;
    //         en     vld   ch     half   clk    rise   run    err   rdy
    tbl[0]  = '{2'b11, 1'b0, 4'd0, 8'd0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1};
    tbl[1]  = '{2'b11, 1'b0, 4'd0, 8'd0, 2'b11, 2'b11, 2'b11, 1'b0, 1'b1};
    tbl[2]  = '{2'b11, 1'b1, 4'd9, 8'd5, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1};
    tbl[3]  = '{2'b11, 1'b0, 4'd0, 8'd0, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1};
    tbl[4]  = '{2'b11, 1'b1, 4'd1, 8'd0, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1};
    tbl[5]  = '{2'b11, 1'b1, 4'd1, 8'd7, 2'b11, 2'b11, 2'b11, 1'b1, 1'b0};
    tbl[6]  = '{2'b11, 1'b0, 4'd1, 8'd0, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0};
    tbl[7]  = '{2'b11, 1'b0, 4'd1, 8'd0, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1};
    tbl[8]  = '{2'b10, 1'b0, 4'd0, 8'd0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1};
    tbl[9]  = '{2'b10, 1'b0, 4'd0, 8'd0, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[10] = '{2'b11, 1'b0, 4'd0, 8'd0, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1};
    tbl[11] = '{2'b11, 1'b0, 4'd0, 8'd0, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1};
    tbl[12] = '{2'b01, 1'b0, 4'd0, 8'd0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1};
    tbl[13] = '{2'b01, 1'b0, 4'd0, 8'd0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1};
    tbl[14] = '{2'b00, 1'b0, 4'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[15] = '{2'b00, 1'b0, 4'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      en_in = tbl[i].en; cfg_valid = tbl[i].vld; cfg_ch = tbl[i].ch; cfg_half = tbl[i].half;
      tick();
      check($sformatf("tbl%0d_rdy", i), rdy_pre, tbl[i].rdy);
      check($sformatf("tbl%0d_clk", i), clock_out, tbl[i].clk);
      check($sformatf("tbl%0d_rise", i), rise_pulse, tbl[i].rise);
      check($sformatf("tbl%0d_run", i), running, tbl[i].run);
      check($sformatf("tbl%0d_err", i), cfg_err, tbl[i].err);
    end
    cfg_valid = 1'b0;

    // Ratio change from 1 to 3, write landing on a rising edge of ch0.
    do_reset();
    en_in = '1;
    tick(); tick(); tick();
    cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_half = 8'd3;
    tick();
    check("A_accept", rdy_pre, 1);
    cfg_valid = 1'b0;
    tick();
    check("A_rdy_low_while_pending", rdy_pre, 0);
    run_len(0, 1'b0, n); check("A_low3", n, 3);
    run_len(0, 1'b1, n); check("A_high3", n, 3);
    run_len(0, 1'b0, n); check("A_low3_again", n, 3);

    // Back-to-back writes on ch1 at half 4: second stalls until the first applies.
    cfg_write(1, 4);
    wait_pend(1);
    cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_half = 8'd5;
    tick();
    check("B_first_accept", rdy_pre, 1);
    cfg_half = 8'd2;
    stall = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (rdy_pre) break;
      stall++;
    end
    cfg_valid = 1'b0;
    check("B_stall_cycles", stall, 7);
    run_len(1, 1'b0, n); check("B_low_rest", n, 4);
    run_len(1, 1'b1, n); check("B_high5", n, 5);
    run_len(1, 1'b0, n); check("B_low2", n, 2);
    run_len(1, 1'b1, n); check("B_high2", n, 2);

    // Enable dropped one cycle into a half=4 high phase, then re-enabled.
    cfg_write(0, 4);
    wait_pend(0);
    run_len(0, 1'b0, n); check("C_low4", n, 4);
    en_in[0] = 1'b0;
    run_len(0, 1'b1, n); check("C_high_completes", n, 4);
    check("C_stopped", running[0], 0);
    repeat (5) tick();
    check("C_held_low", clock_out[0], 0);
    check("C_still_stopped", running[0], 0);
    en_in[0] = 1'b1;
    tick();
    check("C_restart", running[0], 1);
    run_len(0, 1'b0, n); check("C_first_rise", n, 4);

    // Largest legal half period.
    cfg_write(1, 255);
    wait_pend(1);
    run_len(1, 1'b0, n); check("D_low_max", n, 255);
    run_len(1, 1'b1, n); check("D_high_max", n, 255);

    // Asynchronous reset in the middle of a half=7 high phase, with a config pending.
    cfg_write(0, 7);
    wait_pend(0);
    run_len(0, 1'b0, n); check("E_low7", n, 7);
    tick(); tick();
    cfg_write(1, 3);
    #3 reset_n = 1'b0;
    #1;
    check("E_async_clk", clock_out, 0);
    check("E_async_run", running, 0);
    check("E_async_rise", rise_pulse, 0);
    cfg_ch = 4'd1;
    #1;
    check("E_pend_lost", cfg_ready, 1);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    en_in = '1;
    tick(); tick();
    run_len(0, 1'b1, n); check("E_default_high", n, 1);
    run_len(0, 1'b0, n); check("E_default_low", n, 1);
    run_len(1, 1'b1, n); check("E_ch1_default", n, 1);

    // Random traffic against the model.
    do_reset();
    en_in = '1;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 15) == 0) en_in[c] = ~en_in[c];
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      cfg_half  = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(0, 255)) : CNT_W'($urandom_range(0, 6));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
